// File: rtl/ysyx_22040632_idu_exu.sv
// Two-stage decode/execute unit for the RV OP-IMM / OP-IMM-32 groups.
// S1 latches the instruction, S2 holds the result; the register file is written as S1 advances.
module ysyx_22040632_idu_exu #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter bit RV64W = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_wen,
  output logic            out_illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int         IDXW  = (NREG == 16) ? 4 : 5;
  localparam logic [5:0] NREGV = 6'(NREG);
  localparam bit         HASW  = (XLEN == 64) && RV64W;

  logic            r_s1Valid;
  logic [31:0]     r_s1Instr;
  logic            r_outValid;
  logic [4:0]      r_outRd;
  logic [XLEN-1:0] r_outData;
  logic            r_outWen;
  logic            r_outIll;
  logic [XLEN-1:0] r_regs [NREG];

  logic            w_s1Adv;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rdIdx;
  logic [4:0]      w_rs1Idx;
  logic [5:0]      w_top6;
  logic [5:0]      w_shamt;
  logic [4:0]      w_shamtW;
  logic            w_shamtBad;
  logic            w_regRangeBad;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1Val;
  logic [31:0]     w_res32;
  logic [XLEN-1:0] w_res;
  logic            w_ill;
  logic            w_wen;

  assign w_s1Adv  = r_s1Valid && (!r_outValid || out_ready);
  assign in_ready = !rst && (!r_s1Valid || w_s1Adv);

  assign w_opcode   = r_s1Instr[6:0];
  assign w_rdIdx    = r_s1Instr[11:7];
  assign w_funct3   = r_s1Instr[14:12];
  assign w_rs1Idx   = r_s1Instr[19:15];
  assign w_top6     = r_s1Instr[31:26];
  assign w_imm      = XLEN'($signed(r_s1Instr[31:20]));
  assign w_shamt    = (XLEN == 64) ? r_s1Instr[25:20] : {1'b0, r_s1Instr[24:20]};
  assign w_shamtW   = r_s1Instr[24:20];
  // A 6-bit shift amount is only meaningful on a 64-bit datapath
  assign w_shamtBad = (XLEN == 32) && r_s1Instr[25];

  assign w_regRangeBad = ({1'b0, w_rs1Idx} >= NREGV) || ({1'b0, w_rdIdx} >= NREGV);
  assign w_rs1Val = (w_rs1Idx != 5'd0 && {1'b0, w_rs1Idx} < NREGV) ? r_regs[w_rs1Idx[IDXW-1:0]] : '0;

  always_comb begin
    w_res   = '0;
    w_res32 = '0;
    w_ill   = 1'b0;
    case (w_opcode)
      7'b0010011: begin
        case (w_funct3)
          3'b000: w_res = w_rs1Val + w_imm;
          3'b010: w_res = {{(XLEN-1){1'b0}}, ($signed(w_rs1Val) < $signed(w_imm))};
          3'b011: w_res = {{(XLEN-1){1'b0}}, (w_rs1Val < w_imm)};
          3'b100: w_res = w_rs1Val ^ w_imm;
          3'b110: w_res = w_rs1Val | w_imm;
          3'b111: w_res = w_rs1Val & w_imm;
          3'b001: begin
            if (w_top6 != 6'b000000 || w_shamtBad) w_ill = 1'b1;
            else w_res = w_rs1Val << w_shamt;
          end
          default: begin
            if (w_shamtBad) w_ill = 1'b1;
            else if (w_top6 == 6'b000000) w_res = w_rs1Val >> w_shamt;
            else if (w_top6 == 6'b010000) w_res = $signed(w_rs1Val) >>> w_shamt;
            else w_ill = 1'b1;
          end
        endcase
      end
      7'b0011011: begin
        if (!HASW) begin
          w_ill = 1'b1;
        end else begin
          case (w_funct3)
            3'b000: w_res32 = w_rs1Val[31:0] + w_imm[31:0];
            3'b001: begin
              if (r_s1Instr[31:25] != 7'b0000000) w_ill = 1'b1;
              else w_res32 = w_rs1Val[31:0] << w_shamtW;
            end
            3'b101: begin
              if (r_s1Instr[31:25] == 7'b0000000) w_res32 = w_rs1Val[31:0] >> w_shamtW;
              else if (r_s1Instr[31:25] == 7'b0100000) w_res32 = $signed(w_rs1Val[31:0]) >>> w_shamtW;
              else w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
          endcase
          w_res = XLEN'($signed(w_res32));
        end
      end
      default: w_ill = 1'b1;
    endcase
    if (w_regRangeBad) w_ill = 1'b1;
    if (w_ill) w_res = '0;
  end

  assign w_wen = !w_ill && (w_rdIdx != 5'd0);

  // Reset wins over any write that would have landed on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid  <= 1'b0;
      r_outValid <= 1'b0;
      r_outRd    <= '0;
      r_outData  <= '0;
      r_outWen   <= 1'b0;
      r_outIll   <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (in_valid && in_ready) begin
        r_s1Valid <= 1'b1;
        r_s1Instr <= in_instr;
      end else if (w_s1Adv) begin
        r_s1Valid <= 1'b0;
      end
      if (w_s1Adv) begin
        r_outValid <= 1'b1;
        r_outRd    <= w_rdIdx;
        r_outData  <= w_res;
        r_outWen   <= w_wen;
        r_outIll   <= w_ill;
        if (w_wen) r_regs[w_rdIdx[IDXW-1:0]] <= w_res;
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_outValid;
  assign out_rd      = r_outRd;
  assign out_data    = r_outData;
  assign out_wen     = r_outWen;
  assign out_illegal = r_outIll;
  assign dbg_rdata   = (dbg_raddr != 5'd0 && {1'b0, dbg_raddr} < NREGV) ? r_regs[dbg_raddr[IDXW-1:0]] : '0;

endmodule

// File: tb/tb_ysyx_22040632_idu_exu.sv
// Self-checking bench: directed vector table, hand-written pipeline sequences,
// a 32-bit/RV-E parameter instance, and randomized streams against a reference model.
module tb_ysyx_22040632_idu_exu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_wen, out_illegal;
  logic [31:0] in_instr;
  logic [4:0]  out_rd, dbg_raddr;
  logic [63:0] out_data, dbg_rdata;

  logic        in_valid2, in_ready2, out_valid2, out_wen2, out_illegal2;
  logic [31:0] in_instr2, out_data2, dbg_rdata2;
  logic [4:0]  out_rd2, dbg_raddr2;

  always #5 clk = ~clk;

  ysyx_22040632_idu_exu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_wen(out_wen), .out_illegal(out_illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  ysyx_22040632_idu_exu #(.XLEN(32), .NREG(16), .RV64W(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_rd(out_rd2), .out_data(out_data2),
    .out_wen(out_wen2), .out_illegal(out_illegal2), .dbg_raddr(dbg_raddr2), .dbg_rdata(dbg_rdata2)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        wen;
    logic        ill;
  } result_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        wen;
    logic        ill;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] mregs [32];
  logic [31:0] pendQ [$];
  result_t     expQ [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Architectural reference: executes one instruction on the model register file
  function automatic result_t refModel(input logic [31:0] ins);
    result_t     r;
    logic [63:0] a, imm;
    logic [31:0] w;
    logic [5:0]  sh;
    r.rd = ins[11:7];
    r.ill = 1'b0;
    r.data = 64'd0;
    w = 32'd0;
    a = (ins[19:15] == 5'd0) ? 64'd0 : mregs[ins[19:15]];
    imm = {{52{ins[31]}}, ins[31:20]};
    sh = ins[25:20];
    case (ins[6:0])
      7'h13: begin
        case (ins[14:12])
          3'd0: r.data = a + imm;
          3'd2: r.data = ($signed(a) < $signed(imm)) ? 64'd1 : 64'd0;
          3'd3: r.data = (a < imm) ? 64'd1 : 64'd0;
          3'd4: r.data = a ^ imm;
          3'd6: r.data = a | imm;
          3'd7: r.data = a & imm;
          3'd1: if (ins[31:26] == 6'd0) r.data = a << sh; else r.ill = 1'b1;
          default: begin
            if (ins[31:26] == 6'd0) r.data = a >> sh;
            else if (ins[31:26] == 6'b010000) r.data = $signed(a) >>> sh;
            else r.ill = 1'b1;
          end
        endcase
      end
      7'h1B: begin
        case (ins[14:12])
          3'd0: w = a[31:0] + imm[31:0];
          3'd1: if (ins[31:25] == 7'd0) w = a[31:0] << ins[24:20]; else r.ill = 1'b1;
          3'd5: begin
            if (ins[31:25] == 7'd0) w = a[31:0] >> ins[24:20];
            else if (ins[31:25] == 7'b0100000) w = $signed(a[31:0]) >>> ins[24:20];
            else r.ill = 1'b1;
          end
          default: r.ill = 1'b1;
        endcase
        r.data = {{32{w[31]}}, w};
      end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) r.data = 64'd0;
    r.wen = !r.ill && (r.rd != 5'd0);
    if (r.wen) mregs[r.rd] = r.data;
    return r;
  endfunction

  function automatic logic [31:0] randInstr();
    int          r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1;
    logic [11:0] imm;
    r = $urandom_range(0, 19);
    if (r == 0) return $urandom;
    op = (r < 14) ? 7'h13 : 7'h1B;
    f3 = 3'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    if ((f3 == 3'd1 || f3 == 3'd5) && $urandom_range(0, 7) != 0) begin
      imm[11:6] = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 6'b010000 : 6'b000000;
      if (op == 7'h1B) imm[5] = 1'b0;
    end
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      #1;
      checkOutput($sformatf("%s x%0d", tag, i), dbg_rdata, (i == 0) ? 64'd0 : mregs[i]);
    end
  endtask

  // Offer one instruction with out_ready=1 and wait for its result; lat counts negedges after acceptance
  task automatic sendOne(input logic [31:0] ins, output result_t got, output int lat);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      checks++; failures++;
      $display("[TB] FAIL acceptTimeout instr=0x%08h actual=in_ready_low required=accept", ins);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got.rd = out_rd;
    got.data = out_data;
    got.wen = out_wen;
    got.ill = out_illegal;
  endtask

  task automatic send2(input logic [31:0] ins, output result_t got);
    int n;
    @(negedge clk);
    in_valid2 = 1'b1;
    in_instr2 = ins;
    #1;
    checkOutput("dut2 inReady", in_ready2, 1'b1);
    @(negedge clk);
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("dut2 outValid", out_valid2, 1'b1);
    got.rd = out_rd2;
    got.data = {32'd0, out_data2};
    got.wen = out_wen2;
    got.ill = out_illegal2;
  endtask

  // Randomized stream with random in_valid/out_ready, scoreboarded against refModel
  task automatic applyStimulus(input int nInstr, input int validPct, input int readyPct);
    int      cyc;
    bit      prevHold;
    result_t prevOut, e;
    cyc = 0;
    prevHold = 1'b0;
    prevOut = '{default: '0};
    for (int i = 0; i < nInstr; i++) pendQ.push_back(randInstr());
    while ((pendQ.size() > 0 || expQ.size() > 0) && cyc < nInstr * 20 + 50) begin
      @(negedge clk);
      if (prevHold) begin
        checkOutput("holdValid", out_valid, 1'b1);
        checkOutput("holdData", out_data, prevOut.data);
        checkOutput("holdRd", out_rd, prevOut.rd);
      end
      out_ready = ($urandom_range(0, 99) < readyPct);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL spuriousOut actual=out_valid required=no_result_pending");
        end else begin
          e = expQ.pop_front();
          checkOutput("rnd illegal", out_illegal, e.ill);
          checkOutput("rnd wen", out_wen, e.wen);
          checkOutput("rnd data", out_data, e.data);
          if (!e.ill) checkOutput("rnd rd", out_rd, e.rd);
        end
      end
      prevHold = out_valid && !out_ready;
      prevOut.data = out_data;
      prevOut.rd = out_rd;
      in_valid = (pendQ.size() > 0) && ($urandom_range(0, 99) < validPct);
      in_instr = (pendQ.size() > 0) ? pendQ[0] : $urandom;
      #1;
      if (in_valid && in_ready) begin
        void'(pendQ.pop_front());
        expQ.push_back(refModel(in_instr));
      end
      cyc++;
    end
    if (pendQ.size() > 0 || expQ.size() > 0) begin
      checks++; failures++;
      $display("[TB] FAIL streamTimeout actual=pending%0d/outstanding%0d required=0/0", pendQ.size(), expQ.size());
      pendQ.delete();
      expQ.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkRegs("rndRegs");
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t    vecs [11];
    vec_t    vecs2 [6];
    result_t got;
    int      lat;
    logic [31:0] bpInstr [3];

    vecs[0]  = '{32'h00500093, 5'd1, 64'd5, 1'b1, 1'b0};
    vecs[1]  = '{32'hFFF03113, 5'd2, 64'd1, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000000, 5'd0, 64'd0, 1'b0, 1'b1};
    vecs[3]  = '{32'h04109193, 5'd3, 64'd0, 1'b0, 1'b1};
    vecs[4]  = '{32'h00700013, 5'd0, 64'd7, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFF00093, 5'd1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0};
    vecs[6]  = '{32'h0210D093, 5'd1, 64'h000000007FFFFFFF, 1'b1, 1'b0};
    vecs[7]  = '{32'h0010811B, 5'd2, 64'hFFFFFFFF80000000, 1'b1, 1'b0};
    vecs[8]  = '{32'h00100193, 5'd3, 64'd1, 1'b1, 1'b0};
    vecs[9]  = '{32'h03F19193, 5'd3, 64'h8000000000000000, 1'b1, 1'b0};
    vecs[10] = '{32'h43F1D213, 5'd4, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0};

    vecs2[0] = '{32'h0010811B, 5'd2, 64'd0, 1'b0, 1'b1};
    vecs2[1] = '{32'h00100A13, 5'd20, 64'd0, 1'b0, 1'b1};
    vecs2[2] = '{32'hFFD00293, 5'd5, 64'h00000000FFFFFFFD, 1'b1, 1'b0};
    vecs2[3] = '{32'h02009093, 5'd1, 64'd0, 1'b0, 1'b1};
    vecs2[4] = '{32'h4012D313, 5'd6, 64'h00000000FFFFFFFE, 1'b1, 1'b0};
    vecs2[5] = '{32'h00088093, 5'd1, 64'd0, 1'b0, 1'b1};

    bpInstr[0] = 32'h00A00293;
    bpInstr[1] = 32'h01400313;
    bpInstr[2] = 32'h01E00393;

    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    rst = 1'b1;
    in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1; dbg_raddr = 5'd0;
    in_valid2 = 1'b0; in_instr2 = 32'd0; dbg_raddr2 = 5'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst inReady", in_ready, 1'b0);
    checkOutput("rst outValid", out_valid, 1'b0);
    checkOutput("rst outRd", out_rd, 5'd0);
    checkOutput("rst outData", out_data, 64'd0);
    checkOutput("rst outWen", out_wen, 1'b0);
    checkOutput("rst outIllegal", out_illegal, 1'b0);
    checkOutput("rst dut2 inReady", in_ready2, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("postRst inReady", in_ready, 1'b1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 11; i++) begin
      sendOne(vecs[i].instr, got, lat);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
      checkOutput($sformatf("vec%0d illegal", i), got.ill, vecs[i].ill);
      checkOutput($sformatf("vec%0d wen", i), got.wen, vecs[i].wen);
      checkOutput($sformatf("vec%0d data", i), got.data, vecs[i].data);
      if (!vecs[i].ill) checkOutput($sformatf("vec%0d rd", i), got.rd, vecs[i].rd);
      if (vecs[i].wen) mregs[vecs[i].rd] = vecs[i].data;
      dbg_raddr = vecs[i].rd;
      #1;
      checkOutput($sformatf("vec%0d dbg", i), dbg_rdata, (vecs[i].rd == 5'd0) ? 64'd0 : mregs[vecs[i].rd]);
    end
    checkRegs("tableRegs");

    $display("[TB] back-to-back addi x1,x1,1");
    sendOne(32'h00500093, got, lat);
    checkOutput("b2b seed", got.data, 64'd5);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2) begin
        checkOutput($sformatf("b2b valid%0d", c), out_valid, 1'b1);
        checkOutput($sformatf("b2b data%0d", c), out_data, 64'(6 + c - 2));
      end
      in_valid = (c < 3);
      in_instr = 32'h00108093;
      #1;
      if (c < 3) checkOutput($sformatf("b2b inReady%0d", c), in_ready, 1'b1);
    end
    mregs[1] = 64'd8;
    repeat (2) @(negedge clk);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = 1'b1;
      in_instr = bpInstr[k];
      #1;
      checkOutput($sformatf("bp inReady%0d", k), in_ready, (k < 2) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp stallInReady", in_ready, 1'b0);
      checkOutput("bp stallValid", out_valid, 1'b1);
      checkOutput("bp stallData", out_data, 64'd10);
      checkOutput("bp stallRd", out_rd, 5'd5);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp releaseInReady", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp second", out_data, 64'd20);
    checkOutput("bp secondRd", out_rd, 5'd6);
    @(negedge clk);
    checkOutput("bp third", out_data, 64'd30);
    checkOutput("bp thirdValid", out_valid, 1'b1);
    @(negedge clk);
    checkOutput("bp noDup", out_valid, 1'b0);
    mregs[5] = 64'd10; mregs[6] = 64'd20; mregs[7] = 64'd30;
    checkRegs("bpRegs");

    $display("[TB] reset mid-stream");
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00100413;
    @(negedge clk);
    in_instr = 32'h00200493;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midRst s2Full", out_valid, 1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("midRst inReadyLow", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRst outValid", out_valid, 1'b0);
    #1;
    checkOutput("midRst inReady", in_ready, 1'b1);
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    checkRegs("midRstRegs");
    sendOne(32'h00308093, got, lat);
    checkOutput("midRst fresh data", got.data, 64'd3);
    checkOutput("midRst fresh wen", got.wen, 1'b1);
    mregs[1] = 64'd3;

    $display("[TB] XLEN=32 NREG=16 instance");
    for (int i = 0; i < 6; i++) begin
      send2(vecs2[i].instr, got);
      checkOutput($sformatf("dut2 vec%0d illegal", i), got.ill, vecs2[i].ill);
      checkOutput($sformatf("dut2 vec%0d wen", i), got.wen, vecs2[i].wen);
      checkOutput($sformatf("dut2 vec%0d data", i), got.data, vecs2[i].data);
    end
    dbg_raddr2 = 5'd6;
    #1;
    checkOutput("dut2 dbg x6", {32'd0, dbg_rdata2}, 64'h00000000FFFFFFFE);
    dbg_raddr2 = 5'd20;
    #1;
    checkOutput("dut2 dbg x20", {32'd0, dbg_rdata2}, 64'd0);

    $display("[TB] randomized streams");
    applyStimulus(200, 70, 70);
    applyStimulus(150, 100, 100);
    applyStimulus(150, 90, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
